parking_controller: RTL and testbench
=====================================

# parking_controller

Parametrised entry/exit controller for a car park with a configurable number of bays. It tracks occupancy with a saturating counter and refuses entry when the car park is full. Entry needs a multi-bit password with a retry budget, and the gate is held open by a timed cycle. It sits between the entrance/exit vehicle sensors, the keypad front-end and the gate/LED drivers. It replaces the fixed 2-bit, fixed-capacity parking FSM.

## Interface
Parameters:
- CAPACITY, 8: number of bays; must be at least 1.
- PASS_W, 4: password width in bits.
- PASS_KEY, 4'hB: accepted password value, PASS_W bits wide.
- MAX_TRIES, 3: consecutive wrong entries before lockout; used only with lockout compiled in.
- GATE_CYCLES, 16: number of cycles GREEN_LED and gate_open stay high per entry.
- PASS_TIMEOUT, 64: cycles to wait for a password before abandoning the request.
- LOCKOUT_CYCLES, 128: lockout duration in cycles.

Ports:
- clk, input, 1: the single clock; everything is on the rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- sensor_entrance, input, 1: level signal, high while a car waits at the entrance.
- sensor_exit, input, 1: level signal, high while a car is at the exit. A rising edge means one departure.
- pass_valid, input, 1: one-cycle strobe; the `password` value is valid in that cycle.
- password, input, PASS_W: keypad value.
- GREEN_LED, output, 1: entry granted.
- RED_LED, output, 1: wrong password, lockout, or refused because the car park is full.
- gate_open, output, 1: gate actuator drive.
- FULL, output, 1: high when count == CAPACITY.
- count, output, CW = $clog2(CAPACITY+1): current occupancy.
- alarm, output, 1: high during lockout.

## Operation
- States: IDLE, WAIT_PASS, WRONG_PASS, GATE, LOCKOUT. All outputs are registered.
- **IDLE**
  - A rising edge of sensor_entrance with FULL=0 moves to WAIT_PASS and starts the timeout counter.
  - If FULL=1, stay in IDLE. RED_LED follows sensor_entrance, with a one-cycle register delay, for as long as the request is refused.
- **WAIT_PASS / WRONG_PASS**
  - pass_valid with password == PASS_KEY moves to GATE and clears the try counter.
  - pass_valid with a wrong password moves to or stays in WRONG_PASS and increments the try counter. The timeout counter restarts.
  - No pass_valid for PASS_TIMEOUT cycles returns to IDLE and clears the try counter.
  - pass_valid in any other state is ignored.
- **GATE**
  - On entry: count increments and the gate timer loads GATE_CYCLES.
  - GREEN_LED = gate_open = 1 while in GATE. Return to IDLE when the timer reaches 0.
- **LOCKOUT** (macro only)
  - alarm = RED_LED = 1 for LOCKOUT_CYCLES, then IDLE with the try counter cleared.
  - sensor_entrance edges and pass_valid are ignored during lockout.
- **Exit path:** independent of the FSM. A sensor_exit rising edge decrements count if count > 0. With count == 0 the edge is ignored and count stays 0.
- **Simultaneous increment and decrement** in the same cycle leave count unchanged.
- **Invariant:** count never exceeds CAPACITY. An increment is only possible from WAIT_PASS or WRONG_PASS, which are only reached with FULL=0.
- **Edge detection:** sensor_entrance and sensor_exit each have a one-flop history register, reset to 0. A sensor held high at reset release produces no edge.

## Timing
- Reset values: state=IDLE, count=0, FULL=0, GREEN_LED=0, RED_LED=0, gate_open=0, alarm=0, all timers and try counter 0.
- Reset asserted mid-operation clears everything immediately, asynchronously. Occupancy is lost.
- Sensor edge to state change: 1 cycle. The edge is seen in cycle N; the state register updates at the end of cycle N, so outputs are valid in N+1.
- Correct pass_valid in cycle N: GREEN_LED, gate_open and the updated count are visible from N+1. They stay high for exactly GATE_CYCLES cycles.
- Wrong pass_valid in cycle N: RED_LED is high from N+1.
- FULL updates in the same cycle as count.
- Timeout: the return to IDLE happens PASS_TIMEOUT cycles after the last pass_valid or after entering WAIT_PASS.

## Configuration
- Macro: PARKING_LOCKOUT_EN.
- Defined:
  - Wrong-password attempts are counted.
  - The MAX_TRIES-th consecutive wrong attempt moves to LOCKOUT.
  - alarm is driven as described in Operation.
- Undefined:
  - Unlimited retries; WRONG_PASS is exited only by a correct password or by timeout.
  - The LOCKOUT state, try counter and lockout timer are not built. alarm is tied to 0.

## Test plan
- **Basic entry:** reset; entrance edge; pass_valid with 4'hB → GREEN_LED=gate_open=1 for 16 cycles, count=1, then IDLE with LEDs 0.
- **Fill and refuse:** 8 successful entries → count=8, FULL=1. A 9th entrance edge → state stays IDLE, RED_LED=1 while the sensor is high, count stays 8.
- **Exit and underflow:** from count=2, three exit edges → count 1, 0, 0; FULL=0 throughout.
- **Simultaneous events:** count=5; correct password in the same cycle as an exit edge → count=5 the next cycle, gate opens.
- **Wrong password and lockout (macro defined):** passwords 0, 1, 2 → RED_LED=1 after the first, alarm=1 for 128 cycles after the third; a correct key during lockout is ignored; then IDLE.
  - Macro undefined: the same stimulus leaves the FSM in WRONG_PASS with alarm=0; 4'hB then opens the gate.
- **Timeout and reset:**
  - Entrance edge with no pass_valid for 64 cycles → IDLE.
  - reset_n pulled low mid-GATE with count=3 → all outputs 0 and count=0 without waiting for a clock edge.

Source files
------------

// File: rtl/parking_controller.sv
// parking_controller: entry/exit controller for a car park with CAPACITY bays.
// A rising edge on the entrance sensor starts a password request when the car
// park is not full. A correct key opens the gate for GATE_CYCLES cycles and
// admits one car. A rising edge on the exit sensor removes one car. The
// occupancy counter saturates at 0 and at CAPACITY.
// Optional feature macro PARKING_LOCKOUT_EN: MAX_TRIES consecutive wrong keys
// start a LOCKOUT_CYCLES lockout that drives alarm. Without the macro, retries
// are unlimited and alarm is tied low.
// Ports:
//   clk             rising-edge clock
//   reset_n         asynchronous active-low reset
//   sensor_entrance level, car waiting at the entrance
//   sensor_exit     level, rising edge = one departure
//   pass_valid      one-cycle strobe qualifying password
//   password        keypad value
//   GREEN_LED       entry granted (registered)
//   RED_LED         wrong key, lockout or refused because full (registered)
//   gate_open       gate actuator drive (registered, equal to GREEN_LED)
//   FULL            count == CAPACITY (registered)
//   count           current occupancy (registered)
//   alarm           lockout active (registered; 0 without the macro)
module parking_controller #(
  parameter int unsigned       CAPACITY       = 8,
  parameter int unsigned       PASS_W         = 4,
  parameter logic [PASS_W-1:0] PASS_KEY       = 4'hB,
  parameter int unsigned       MAX_TRIES      = 3,
  parameter int unsigned       GATE_CYCLES    = 16,
  parameter int unsigned       PASS_TIMEOUT   = 64,
  parameter int unsigned       LOCKOUT_CYCLES = 128
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               sensor_entrance,
  input  logic                               sensor_exit,
  input  logic                               pass_valid,
  input  logic [PASS_W-1:0]                  password,
  output logic                               GREEN_LED,
  output logic                               RED_LED,
  output logic                               gate_open,
  output logic                               FULL,
  output logic [$clog2(CAPACITY+1)-1:0]      count,
  output logic                               alarm
);

  localparam int unsigned CW   = $clog2(CAPACITY + 1);
  localparam int unsigned T1   = (GATE_CYCLES > PASS_TIMEOUT) ? GATE_CYCLES : PASS_TIMEOUT;
  localparam int unsigned TMAX = (T1 > LOCKOUT_CYCLES) ? T1 : LOCKOUT_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  if (CAPACITY == 0 || MAX_TRIES == 0) begin : g_param_check
    $error("parking_controller: CAPACITY and MAX_TRIES must be at least 1");
  end

  typedef enum logic [2:0] {IDLE, WAIT_PASS, WRONG_PASS, GATE, LOCKOUT} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full_q, full_d;
  logic            green_q, green_d;
  logic            red_q, red_d;
  logic            ent_q, ex_q, armed_q;
  logic            ent_rise, ex_rise, inc, inc_ok, dec_ok;

`ifdef PARKING_LOCKOUT_EN
  localparam int unsigned TRW = $clog2(MAX_TRIES + 1);
  logic [TRW-1:0]  tries_q, tries_d;
  logic            alarm_q, alarm_d;
`endif

  // History flops reset to 0, so armed_q blanks the first sampled cycle after
  // reset: a sensor already high at release must not look like an arrival.
  assign ent_rise = armed_q & sensor_entrance & ~ent_q;
  assign ex_rise  = armed_q & sensor_exit & ~ex_q;

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      green_q <= 1'b0;
      red_q   <= 1'b0;
      ent_q   <= 1'b0;
      ex_q    <= 1'b0;
      armed_q <= 1'b0;
`ifdef PARKING_LOCKOUT_EN
      tries_q <= '0;
      alarm_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      count_q <= count_d;
      full_q  <= full_d;
      green_q <= green_d;
      red_q   <= red_d;
      ent_q   <= sensor_entrance;
      ex_q    <= sensor_exit;
      armed_q <= 1'b1;
`ifdef PARKING_LOCKOUT_EN
      tries_q <= tries_d;
      alarm_q <= alarm_d;
`endif
    end
  end

  // Next state. The shared timer is loaded with N-1 so that a state lasts
  // exactly N cycles, leaving on the cycle the timer reads 0.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    inc     = 1'b0;
`ifdef PARKING_LOCKOUT_EN
    tries_d = tries_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (ent_rise && !full_q) begin
          state_d = WAIT_PASS;
          tmr_d   = TW'(PASS_TIMEOUT - 1);
        end
      end
      WAIT_PASS, WRONG_PASS: begin
        if (pass_valid) begin
          if (password == PASS_KEY) begin
            state_d = GATE;
            tmr_d   = TW'(GATE_CYCLES - 1);
            inc     = 1'b1;
`ifdef PARKING_LOCKOUT_EN
            tries_d = '0;
`endif
          end else begin
            state_d = WRONG_PASS;
            tmr_d   = TW'(PASS_TIMEOUT - 1);
`ifdef PARKING_LOCKOUT_EN
            tries_d = tries_q + 1'b1;
            if (tries_q == TRW'(MAX_TRIES - 1)) begin
              state_d = LOCKOUT;
              tmr_d   = TW'(LOCKOUT_CYCLES - 1);
            end
`endif
          end
        end else if (tmr_q == '0) begin
          state_d = IDLE;
`ifdef PARKING_LOCKOUT_EN
          tries_d = '0;
`endif
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      GATE: begin
        if (tmr_q == '0) state_d = IDLE;
        else             tmr_d   = tmr_q - 1'b1;
      end
`ifdef PARKING_LOCKOUT_EN
      LOCKOUT: begin
        if (tmr_q == '0) begin
          state_d = IDLE;
          tries_d = '0;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Occupancy and output next values
  always_comb begin
    dec_ok  = ex_rise && (count_q != '0);
    inc_ok  = inc && (count_q != CW'(CAPACITY));
    count_d = count_q;
    if (inc_ok && !dec_ok)      count_d = count_q + 1'b1;
    else if (dec_ok && !inc_ok) count_d = count_q - 1'b1;
    full_d  = (count_d == CW'(CAPACITY));
    green_d = (state_d == GATE);
    // Refusal indication tracks the sensor level while full and idle.
    red_d   = (state_d == WRONG_PASS) || (state_d == LOCKOUT) ||
              ((state_q == IDLE) && full_q && sensor_entrance);
`ifdef PARKING_LOCKOUT_EN
    alarm_d = (state_d == LOCKOUT);
`endif
  end

  assign GREEN_LED = green_q;
  assign gate_open = green_q;
  assign RED_LED   = red_q;
  assign FULL      = full_q;
  assign count     = count_q;
`ifdef PARKING_LOCKOUT_EN
  assign alarm     = alarm_q;
`else
  assign alarm     = 1'b0;
`endif

endmodule

// File: tb/tb_parking_controller.sv
// Testbench for parking_controller: directed stimulus, a cycle model built on
// remaining-cycle counters, a per-cycle compare process, and literal checks.
module tb_parking_controller;

  localparam int unsigned CAP   = 8;
  localparam int unsigned PW    = 4;
  localparam logic [PW-1:0] KEY = 4'hB;
  localparam int unsigned TRIES = 3;
  localparam int unsigned GATEC = 16;
  localparam int unsigned TOUT  = 64;
  localparam int unsigned LOCKC = 128;
  localparam int unsigned CW    = $clog2(CAP + 1);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          sensor_entrance = 1'b0;
  logic          sensor_exit = 1'b0;
  logic          pass_valid = 1'b0;
  logic [PW-1:0] password = '0;
  logic          GREEN_LED, RED_LED, gate_open, FULL, alarm;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  parking_controller #(
    .CAPACITY(CAP), .PASS_W(PW), .PASS_KEY(KEY), .MAX_TRIES(TRIES),
    .GATE_CYCLES(GATEC), .PASS_TIMEOUT(TOUT), .LOCKOUT_CYCLES(LOCKC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sensor_entrance(sensor_entrance),
    .sensor_exit(sensor_exit), .pass_valid(pass_valid), .password(password),
    .GREEN_LED(GREEN_LED), .RED_LED(RED_LED), .gate_open(gate_open),
    .FULL(FULL), .count(count), .alarm(alarm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each activity is a count of cycles it still has to run.
  int unsigned m_count = 0, m_wait = 0, m_gate = 0, m_lock = 0, m_tries = 0;
  bit m_bad = 0, m_refuse = 0, m_ent_p = 0, m_ex_p = 0, m_armed = 0;
  bit erise, xrise, idle_now, full_now, m_inc, m_dec;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_count = 0; m_wait = 0; m_gate = 0; m_lock = 0; m_tries = 0;
      m_bad = 0; m_refuse = 0; m_ent_p = 0; m_ex_p = 0; m_armed = 0;
    end else begin
      erise    = m_armed && sensor_entrance && !m_ent_p;
      xrise    = m_armed && sensor_exit && !m_ex_p;
      m_ent_p  = sensor_entrance;
      m_ex_p   = sensor_exit;
      m_armed  = 1;
      full_now = (m_count == CAP);
      idle_now = (m_wait == 0) && (m_gate == 0) && (m_lock == 0);
      m_refuse = idle_now && full_now && sensor_entrance;
      m_inc    = 0;
      if (m_wait > 0) begin
        if (pass_valid) begin
          if (password == KEY) begin
            m_wait = 0; m_bad = 0; m_tries = 0; m_gate = GATEC; m_inc = 1;
          end else begin
            m_tries++; m_bad = 1; m_wait = TOUT;
`ifdef PARKING_LOCKOUT_EN
            if (m_tries == TRIES) begin
              m_bad = 0; m_wait = 0; m_tries = 0; m_lock = LOCKC;
            end
`endif
          end
        end else begin
          m_wait--;
          if (m_wait == 0) begin m_bad = 0; m_tries = 0; end
        end
      end else if (m_gate > 0) m_gate--;
      else if (m_lock > 0) m_lock--;
      else if (erise && !full_now) m_wait = TOUT;
      m_dec = xrise && (m_count > 0);
      if (m_inc && m_count < CAP) m_count++;
      if (m_dec) m_count--;
    end
  end

  always @(posedge clk) begin
    #1;
    chk("cyc_GREEN_LED", GREEN_LED, m_gate > 0);
    chk("cyc_gate_open", gate_open, m_gate > 0);
    chk("cyc_RED_LED", RED_LED, m_bad || (m_lock > 0) || m_refuse);
    chk("cyc_alarm", alarm, m_lock > 0);
    chk("cyc_count", count, m_count);
    chk("cyc_FULL", FULL, m_count == CAP);
  end

  task automatic cyc(input logic e, input logic x, input logic v, input logic [PW-1:0] p);
    sensor_entrance = e; sensor_exit = x; pass_valid = v; password = p;
    @(negedge clk);
  endtask

  task automatic enter();
    cyc(1, 0, 0, '0);
    cyc(0, 0, 1, KEY);
    repeat (16) cyc(0, 0, 0, '0);
  endtask

  task automatic exit_pulse();
    cyc(0, 1, 0, '0);
    cyc(0, 0, 0, '0);
  endtask

  int unsigned gcnt, acnt, gseen;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_green", GREEN_LED, 0);
    chk("rst_red", RED_LED, 0);
    chk("rst_gate", gate_open, 0);
    chk("rst_full", FULL, 0);
    chk("rst_count", count, 0);
    chk("rst_alarm", alarm, 0);
    reset_n = 1'b1;
    repeat (2) cyc(0, 0, 0, '0);

    // Basic entry
    cyc(1, 0, 0, '0);
    cyc(0, 0, 1, KEY);
    chk("basic_green", GREEN_LED, 1);
    chk("basic_gate", gate_open, 1);
    chk("basic_count", count, 1);
    gcnt = 1;
    repeat (20) begin cyc(0, 0, 0, '0); gcnt += GREEN_LED; end
    chk("basic_green_len", gcnt, 16);
    chk("basic_green_off", GREEN_LED, 0);

    // Fill and refuse
    repeat (7) enter();
    chk("fill_count", count, 8);
    chk("fill_full", FULL, 1);
    cyc(1, 0, 0, '0);
    chk("refuse_red1", RED_LED, 1);
    cyc(1, 0, 0, '0);
    chk("refuse_red2", RED_LED, 1);
    cyc(0, 0, 1, KEY);
    chk("refuse_green", GREEN_LED, 0);
    chk("refuse_red_off", RED_LED, 0);
    chk("refuse_count", count, 8);
    cyc(0, 0, 0, '0);

    // Exit and underflow
    repeat (6) exit_pulse();
    chk("exit_count2", count, 2);
    exit_pulse(); chk("exit_count1", count, 1); chk("exit_full1", FULL, 0);
    exit_pulse(); chk("exit_count0", count, 0); chk("exit_full0", FULL, 0);
    exit_pulse(); chk("exit_under", count, 0); chk("exit_fullu", FULL, 0);

    // Simultaneous entry and exit
    repeat (5) enter();
    chk("sim_pre", count, 5);
    cyc(1, 0, 0, '0);
    cyc(0, 1, 1, KEY);
    chk("sim_count", count, 5);
    chk("sim_green", GREEN_LED, 1);
    repeat (17) cyc(0, 0, 0, '0);

    // Wrong passwords
    cyc(1, 0, 0, '0);
    cyc(0, 0, 1, 4'h0);
    chk("wrong_red1", RED_LED, 1);
    cyc(0, 0, 0, '0);
    cyc(0, 0, 1, 4'h1);
    cyc(0, 0, 0, '0);
    cyc(0, 0, 1, 4'h2);
`ifdef PARKING_LOCKOUT_EN
    chk("lock_alarm", alarm, 1);
    acnt = alarm; gseen = 0;
    for (int i = 0; i < 140; i++) begin
      cyc(0, 0, (i == 20) || (i == 126), KEY);
      acnt += alarm; gseen += GREEN_LED;
    end
    chk("lock_len", acnt, 128);
    chk("lock_key_ignored", gseen, 0);
    chk("lock_count", count, 5);
    chk("lock_red_off", RED_LED, 0);
`else
    chk("nolock_alarm", alarm, 0);
    chk("nolock_red", RED_LED, 1);
    repeat (3) cyc(0, 0, 0, '0);
    chk("nolock_red_hold", RED_LED, 1);
    cyc(0, 0, 1, KEY);
    chk("nolock_green", GREEN_LED, 1);
    chk("nolock_count", count, 6);
    repeat (17) cyc(0, 0, 0, '0);
`endif

    // Timeout: 64 idle cycles abandon the request, 63 do not
    cyc(1, 0, 0, '0);
    repeat (64) cyc(0, 0, 0, '0);
    cyc(0, 0, 1, KEY);
    chk("timeout_green", GREEN_LED, 0);
    cyc(0, 0, 0, '0);
    cyc(1, 0, 0, '0);
    repeat (63) cyc(0, 0, 0, '0);
    cyc(0, 0, 1, KEY);
    chk("timeout_edge_green", GREEN_LED, 1);
    repeat (17) cyc(0, 0, 0, '0);

    // Reset mid-GATE with count 3
    repeat (10) exit_pulse();
    enter(); enter();
    cyc(1, 0, 0, '0);
    cyc(0, 0, 1, KEY);
    repeat (5) cyc(0, 0, 0, '0);
    chk("pre_rst_count", count, 3);
    chk("pre_rst_green", GREEN_LED, 1);
    #2 reset_n = 1'b0; sensor_entrance = 1'b1;
    #1;
    chk("arst_green", GREEN_LED, 0);
    chk("arst_gate", gate_open, 0);
    chk("arst_red", RED_LED, 0);
    chk("arst_full", FULL, 0);
    chk("arst_count", count, 0);
    chk("arst_alarm", alarm, 0);
    @(negedge clk);
    reset_n = 1'b1;
    // Sensor high across reset release is not an arrival
    cyc(1, 0, 0, '0);
    cyc(1, 0, 0, '0);
    cyc(0, 0, 1, KEY);
    chk("held_sensor_green", GREEN_LED, 0);
    chk("held_sensor_count", count, 0);
    repeat (3) cyc(0, 0, 0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
